// File: rtl/axi_pim.sv
// axi_pim: AXI4 slave with an internal word memory, plus a processing-in-memory
// datapath that multiplies the two halves of each accepted write beat.
//
// Parameters:
//   DATA_WIDTH, ADDR_WIDTH, STRB_WIDTH, ID_WIDTH : AXI channel widths
//   PIPELINE_OUTPUT : 1 inserts one register stage on the R channel
//   PWIDTH          : width of the product output q
//
// Ports:
//   clk, rst             : rising-edge clock, asynchronous active-high reset
//   s_axi_aw* / w* / b*  : AXI write address, write data and write response channels
//   s_axi_ar* / r*       : AXI read address and read data channels
//   q                    : product low-half * high-half of the last accepted write beat
//   mac_out              : running sum of write-beat products (0 unless AXI_PIM_MAC_EN)
//
// Build option: define AXI_PIM_MAC_EN to build the MAC accumulator behind mac_out.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. A valid source holds valid and its payload stable until that edge; ready
// never depends combinationally on valid (all ready/valid outputs are registered).
//
// Debug visibility: FSM state is held in wr_state_q (write) and rd_state_q (read).

module axi_pim #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 8,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int ID_WIDTH        = 8,
  parameter int PIPELINE_OUTPUT = 0,
  parameter int PWIDTH          = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [PWIDTH-1:0]     q,
  output logic [DATA_WIDTH-1:0] mac_out
);

  localparam int ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int WORD_AW  = ADDR_WIDTH - ADDR_LSB;
  localparam int DEPTH    = 1 << WORD_AW;
  localparam int HALF     = DATA_WIDTH / 2;

  typedef enum logic [1:0] {WR_IDLE, WR_BURST, WR_RESP} wr_state_t;
  typedef enum logic       {RD_IDLE, RD_BURST} rd_state_t;

  // Memory contents survive reset.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // INCR and WRAP both step by the beat size; FIXED (and reserved) hold.
  // The sum wraps naturally at 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [2:0]            size,
                                                      input logic [1:0]            burst);
    if (burst == 2'b01 || burst == 2'b10) return a + (ADDR_WIDTH'(1) << size);
    else return a;
  endfunction

  // ---------------------------------------------------------------- write side
  wr_state_t             wr_state_q, wr_state_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]            wr_len_q, wr_len_d;
  logic [7:0]            wr_cnt_q, wr_cnt_d;
  logic [2:0]            wr_size_q, wr_size_d;
  logic [1:0]            wr_burst_q, wr_burst_d;
  logic [PWIDTH-1:0]     q_q, q_d;

  logic                  aw_hs;
  logic                  wr_beat;
  logic [ADDR_WIDTH-1:0] wr_next_addr;
  logic [DATA_WIDTH-1:0] beat_prod;

  assign aw_hs        = s_axi_awvalid && awready_q;
  assign wr_beat      = s_axi_wvalid && wready_q;
  assign wr_next_addr = next_addr(wr_addr_q, wr_size_q, wr_burst_q);
  // Two HALF-bit operands give an exact DATA_WIDTH-bit product.
  assign beat_prod    = DATA_WIDTH'(s_axi_wdata[HALF-1:0]) *
                        DATA_WIDTH'(s_axi_wdata[DATA_WIDTH-1:HALF]);

  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bid_d      = bid_q;
    wr_addr_d  = wr_addr_q;
    wr_len_d   = wr_len_q;
    wr_cnt_d   = wr_cnt_q;
    wr_size_d  = wr_size_q;
    wr_burst_d = wr_burst_q;
    q_d        = q_q;
    if (wr_beat) q_d = PWIDTH'(beat_prod);
    case (wr_state_q)
      WR_IDLE: begin
        awready_d = 1'b1;
        if (aw_hs) begin
          bid_d      = s_axi_awid;
          wr_addr_d  = s_axi_awaddr;
          wr_len_d   = s_axi_awlen;
          wr_size_d  = s_axi_awsize;
          wr_burst_d = s_axi_awburst;
          wr_cnt_d   = 8'd0;
          awready_d  = 1'b0;
          wready_d   = 1'b1;
          wr_state_d = WR_BURST;
        end
      end
      WR_BURST: begin
        // Beat count alone ends the burst; wlast is not consulted.
        if (wr_beat) begin
          wr_addr_d = wr_next_addr;
          wr_cnt_d  = wr_cnt_q + 8'd1;
          if (wr_cnt_q == wr_len_q) begin
            wready_d   = 1'b0;
            bvalid_d   = 1'b1;
            wr_state_d = WR_RESP;
          end
        end
      end
      WR_RESP: begin
        if (bvalid_q && s_axi_bready) begin
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= WR_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      wr_addr_q  <= '0;
      wr_len_q   <= '0;
      wr_cnt_q   <= '0;
      wr_size_q  <= '0;
      wr_burst_q <= '0;
      q_q        <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bid_q      <= bid_d;
      wr_addr_q  <= wr_addr_d;
      wr_len_q   <= wr_len_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_size_q  <= wr_size_d;
      wr_burst_q <= wr_burst_d;
      q_q        <= q_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_beat) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (s_axi_wstrb[b]) mem[wr_addr_q[ADDR_WIDTH-1:ADDR_LSB]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = 2'b00;
  assign q             = q_q;

  // ----------------------------------------------------------------- read side
  rd_state_t             rd_state_q, rd_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]            rd_len_q, rd_len_d;
  logic [7:0]            rd_cnt_q, rd_cnt_d;
  logic [2:0]            rd_size_q, rd_size_d;
  logic [1:0]            rd_burst_q, rd_burst_d;

  logic                  ar_hs;
  logic                  core_rready;
  logic [ADDR_WIDTH-1:0] rd_next_addr;

  assign ar_hs        = s_axi_arvalid && arready_q;
  assign rd_next_addr = next_addr(rd_addr_q, rd_size_q, rd_burst_q);

  // Read data is fetched from the array before this edge's write lands, so a
  // same-cycle read and write of one word returns the old contents.
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    rid_d      = rid_q;
    rdata_d    = rdata_q;
    rd_addr_d  = rd_addr_q;
    rd_len_d   = rd_len_q;
    rd_cnt_d   = rd_cnt_q;
    rd_size_d  = rd_size_q;
    rd_burst_d = rd_burst_q;
    case (rd_state_q)
      RD_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          rid_d      = s_axi_arid;
          rd_addr_d  = s_axi_araddr;
          rd_len_d   = s_axi_arlen;
          rd_size_d  = s_axi_arsize;
          rd_burst_d = s_axi_arburst;
          rd_cnt_d   = 8'd0;
          rdata_d    = mem[s_axi_araddr[ADDR_WIDTH-1:ADDR_LSB]];
          rlast_d    = (s_axi_arlen == 8'd0);
          rvalid_d   = 1'b1;
          arready_d  = 1'b0;
          rd_state_d = RD_BURST;
        end
      end
      RD_BURST: begin
        if (rvalid_q && core_rready) begin
          if (rlast_q) begin
            rvalid_d   = 1'b0;
            rlast_d    = 1'b0;
            arready_d  = 1'b1;
            rd_state_d = RD_IDLE;
          end else begin
            rd_addr_d = rd_next_addr;
            rd_cnt_d  = rd_cnt_q + 8'd1;
            rdata_d   = mem[rd_next_addr[ADDR_WIDTH-1:ADDR_LSB]];
            rlast_d   = ((rd_cnt_q + 8'd1) == rd_len_q);
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rid_q      <= '0;
      rdata_q    <= '0;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      rd_cnt_q   <= '0;
      rd_size_q  <= '0;
      rd_burst_q <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rid_q      <= rid_d;
      rdata_q    <= rdata_d;
      rd_addr_q  <= rd_addr_d;
      rd_len_q   <= rd_len_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_size_q  <= rd_size_d;
      rd_burst_q <= rd_burst_d;
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rresp   = 2'b00;

  generate
    if (PIPELINE_OUTPUT != 0) begin : g_r_pipe
      // One-entry output stage: refills whenever it is empty or being drained,
      // so each core beat is copied exactly once.
      logic                  p_rvalid_q, p_rvalid_d;
      logic                  p_rlast_q, p_rlast_d;
      logic [ID_WIDTH-1:0]   p_rid_q, p_rid_d;
      logic [DATA_WIDTH-1:0] p_rdata_q, p_rdata_d;

      assign core_rready = !p_rvalid_q || s_axi_rready;

      always_comb begin
        p_rvalid_d = p_rvalid_q;
        p_rlast_d  = p_rlast_q;
        p_rid_d    = p_rid_q;
        p_rdata_d  = p_rdata_q;
        if (core_rready) begin
          p_rvalid_d = rvalid_q;
          p_rlast_d  = rlast_q;
          p_rid_d    = rid_q;
          p_rdata_d  = rdata_q;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          p_rvalid_q <= 1'b0;
          p_rlast_q  <= 1'b0;
          p_rid_q    <= '0;
          p_rdata_q  <= '0;
        end else begin
          p_rvalid_q <= p_rvalid_d;
          p_rlast_q  <= p_rlast_d;
          p_rid_q    <= p_rid_d;
          p_rdata_q  <= p_rdata_d;
        end
      end

      assign s_axi_rvalid = p_rvalid_q;
      assign s_axi_rlast  = p_rlast_q;
      assign s_axi_rid    = p_rid_q;
      assign s_axi_rdata  = p_rdata_q;
    end else begin : g_r_direct
      assign core_rready  = s_axi_rready;
      assign s_axi_rvalid = rvalid_q;
      assign s_axi_rlast  = rlast_q;
      assign s_axi_rid    = rid_q;
      assign s_axi_rdata  = rdata_q;
    end
  endgenerate

  // ----------------------------------------------------------------------- MAC
`ifdef AXI_PIM_MAC_EN
  logic [DATA_WIDTH-1:0] mac_q, mac_d;

  always_comb begin
    mac_d = mac_q;
    if (wr_beat) mac_d = mac_q + beat_prod;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mac_q <= '0;
    else     mac_q <= mac_d;
  end

  assign mac_out = mac_q;
`else
  assign mac_out = '0;
`endif

  // Sideband inputs carry no meaning for this slave; byte-offset address bits
  // do not select a word.
  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_wlast,
                           s_axi_arlock, s_axi_arcache, s_axi_arprot,
                           wr_addr_q, rd_addr_q};

endmodule

// File: tb/tb_axi_pim.sv
// tb_axi_pim: directed bench for axi_pim. Inputs are driven and outputs sampled
// on the falling clock edge; read data is checked against a scoreboard queue
// filled from a byte-accurate memory model when each read is issued.

module tb_axi_pim;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int SW = 4;
  localparam int IW = 8;
  localparam int PW = 32;
  localparam int LIMIT = 50;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] s_axi_awid;
  logic [AW-1:0] s_axi_awaddr;
  logic [7:0]    s_axi_awlen;
  logic [2:0]    s_axi_awsize;
  logic [1:0]    s_axi_awburst;
  logic          s_axi_awlock;
  logic [3:0]    s_axi_awcache;
  logic [2:0]    s_axi_awprot;
  logic          s_axi_awvalid;
  logic          s_axi_awready;
  logic [DW-1:0] s_axi_wdata;
  logic [SW-1:0] s_axi_wstrb;
  logic          s_axi_wlast;
  logic          s_axi_wvalid;
  logic          s_axi_wready;
  logic [IW-1:0] s_axi_bid;
  logic [1:0]    s_axi_bresp;
  logic          s_axi_bvalid;
  logic          s_axi_bready;
  logic [IW-1:0] s_axi_arid;
  logic [AW-1:0] s_axi_araddr;
  logic [7:0]    s_axi_arlen;
  logic [2:0]    s_axi_arsize;
  logic [1:0]    s_axi_arburst;
  logic          s_axi_arlock;
  logic [3:0]    s_axi_arcache;
  logic [2:0]    s_axi_arprot;
  logic          s_axi_arvalid;
  logic          s_axi_arready;
  logic [IW-1:0] s_axi_rid;
  logic [DW-1:0] s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          s_axi_rlast;
  logic          s_axi_rvalid;
  logic          s_axi_rready;
  logic [PW-1:0] q;
  logic [DW-1:0] mac_out;

  axi_pim dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .q(q), .mac_out(mac_out)
  );

  // ------------------------------------------------------------ clock / reset
  always #5 clk = ~clk;

  // ------------------------------------------------------- model / scoreboard
  logic [DW-1:0] model_mem [64];
  logic [DW-1:0] exp_q [$];
  logic [PW-1:0] m_q;
  logic [DW-1:0] m_mac;
  logic [AW-1:0] m_waddr;
  logic [1:0]    m_wburst;
  int            total = 0;
  int            bad = 0;

`ifdef AXI_PIM_MAC_EN
  localparam logic [DW-1:0] MAC_AFTER_TWO = 32'd24;
`else
  localparam logic [DW-1:0] MAC_AFTER_TWO = 32'd0;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] m_next(input logic [AW-1:0] a, input logic [1:0] burst);
    if (burst == 2'b01 || burst == 2'b10) return a + 8'd4;
    else return a;
  endfunction

  // ------------------------------------------------------------ driver tasks
  task automatic aw_send(input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [IW-1:0] id);
    int n = 0;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
    s_axi_awsize = 3'd2; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    while (!s_axi_awready && n < LIMIT) begin @(negedge clk); n++; end
    check("aw_wait", 64'(n < LIMIT), 64'd1);
    m_waddr = addr; m_wburst = burst;
    @(negedge clk);
    s_axi_awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [DW-1:0] data, input logic [SW-1:0] strb);
    int n = 0;
    logic [DW-1:0] prod;
    s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b1;
    while (!s_axi_wready && n < LIMIT) begin @(negedge clk); n++; end
    check("w_wait", 64'(n < LIMIT), 64'd1);
    for (int b = 0; b < SW; b++)
      if (strb[b]) model_mem[m_waddr[7:2]][8*b +: 8] = data[8*b +: 8];
    prod = DW'(data[15:0]) * DW'(data[31:16]);
    m_q = prod;
`ifdef AXI_PIM_MAC_EN
    m_mac = m_mac + prod;
`endif
    m_waddr = m_next(m_waddr, m_wburst);
    @(negedge clk);
    s_axi_wvalid = 1'b0;
    check("q", 64'(q), 64'(m_q));
    check("mac_out", 64'(mac_out), 64'(m_mac));
  endtask

  task automatic b_take(input logic [IW-1:0] id);
    int n = 0;
    while (!s_axi_bvalid && n < LIMIT) begin @(negedge clk); n++; end
    check("b_wait", 64'(n < LIMIT), 64'd1);
    check("bid", 64'(s_axi_bid), 64'(id));
    check("bresp", 64'(s_axi_bresp), 64'd0);
    repeat (2) begin
      @(negedge clk);
      check("bvalid_hold", 64'(s_axi_bvalid), 64'd1);
    end
    s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;
    check("bvalid_drop", 64'(s_axi_bvalid), 64'd0);
  endtask

  task automatic write_burst(input logic [AW-1:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [IW-1:0] id,
                             input logic [DW-1:0] base, input logic [DW-1:0] step,
                             input logic [SW-1:0] strb);
    aw_send(addr, len, burst, id);
    for (int i = 0; i <= int'(len); i++) w_send(base + DW'(i) * step, strb);
    b_take(id);
  endtask

  task automatic read_burst(input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [IW-1:0] id,
                            input logic toggle);
    int n = 0;
    int beats = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic [DW-1:0] held;
    logic [DW-1:0] exp_w;
    logic [AW-1:0] a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      exp_q.push_back(model_mem[a[7:2]]);
      a = m_next(a, burst);
    end
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arsize = 3'd2; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    while (!s_axi_arready && n < LIMIT) begin @(negedge clk); n++; end
    check("ar_wait", 64'(n < LIMIT), 64'd1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    check("rvalid_latency", 64'(s_axi_rvalid), 64'd1);
    s_axi_rready = 1'b1;
    while (beats <= int'(len) && cyc < 200) begin
      s_axi_rready = toggle ? ~s_axi_rready : 1'b1;
      if (stalled) begin
        check("rvalid_stall", 64'(s_axi_rvalid), 64'd1);
        check("rdata_stable", 64'(s_axi_rdata), 64'(held));
      end
      stalled = 1'b0;
      if (s_axi_rvalid) begin
        if (s_axi_rready) begin
          if (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            check("rdata", 64'(s_axi_rdata), 64'(exp_w));
          end else begin
            check("r_extra_beat", 64'd1, 64'(exp_q.size()));
          end
          check("rid", 64'(s_axi_rid), 64'(id));
          check("rresp", 64'(s_axi_rresp), 64'd0);
          check("rlast", 64'(s_axi_rlast), 64'(beats == int'(len)));
          beats++;
        end else begin
          held = s_axi_rdata;
          stalled = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    s_axi_rready = 1'b0;
    check("r_beats", 64'(beats), 64'(int'(len) + 1));
    check("rvalid_done", 64'(s_axi_rvalid), 64'd0);
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    rst = 1'b1;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
    s_axi_awburst = '0; s_axi_awlock = 1'b0; s_axi_awcache = '0; s_axi_awprot = '0;
    s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
    s_axi_arburst = '0; s_axi_arlock = 1'b0; s_axi_arcache = '0; s_axi_arprot = '0;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    m_q = '0; m_mac = '0; m_waddr = '0; m_wburst = 2'b01;

    // Reset values, then readiness on the first clock after release.
    repeat (3) @(negedge clk);
    check("rst_awready", 64'(s_axi_awready), 64'd0);
    check("rst_arready", 64'(s_axi_arready), 64'd0);
    check("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
    check("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    check("rst_q", 64'(q), 64'd0);
    check("rst_mac", 64'(mac_out), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("awready_after_rst", 64'(s_axi_awready), 64'd1);
    check("arready_after_rst", 64'(s_axi_arready), 64'd1);

    // Product and accumulator: two beats of 0x00030004.
    write_burst(8'h80, 8'd1, 2'b01, 8'd2, 32'h0003_0004, 32'd0, 4'hF);
    check("q_const_12", 64'(q), 64'd12);
    check("mac_const", 64'(mac_out), 64'(MAC_AFTER_TWO));

    // INCR write of DEADBEEF.. to words 0..3, then plain and throttled reads.
    write_burst(8'h00, 8'd3, 2'b01, 8'd1, 32'hDEAD_BEEF, 32'd1, 4'hF);
    read_burst(8'h00, 8'd3, 2'b01, 8'd1, 1'b0);
    read_burst(8'h00, 8'd3, 2'b01, 8'd5, 1'b1);

    // Byte strobe: only byte 0 of an all-ones word changes.
    write_burst(8'h20, 8'd0, 2'b01, 8'd3, 32'hFFFF_FFFF, 32'd0, 4'hF);
    write_burst(8'h20, 8'd0, 2'b01, 8'd3, 32'h1234_5678, 32'd0, 4'b0001);
    exp_q.push_back(32'hFFFF_FF78);
    read_burst(8'h20, 8'd0, 2'b01, 8'd3, 1'b0);
    check("strobe_sb_drain", 64'(exp_q.size()), 64'd1);
    if (exp_q.size() > 0) check("strobe_const", 64'(exp_q.pop_front()), 64'(model_mem[8]));

    // FIXED burst keeps hammering one word; last beat wins.
    write_burst(8'h30, 8'd2, 2'b00, 8'd4, 32'hA0A0_A0A0, 32'd1, 4'hF);
    read_burst(8'h30, 8'd0, 2'b01, 8'd4, 1'b0);

    // INCR across the top of the address space wraps to word 0.
    write_burst(8'hF8, 8'd3, 2'b01, 8'd6, 32'h1111_0000, 32'h0001_0001, 4'hF);
    read_burst(8'hF8, 8'd3, 2'b01, 8'd6, 1'b1);

    // WRAP mode steps like INCR.
    write_burst(8'h44, 8'd1, 2'b10, 8'd9, 32'h5555_0001, 32'd2, 4'hF);
    read_burst(8'h44, 8'd1, 2'b10, 8'd9, 1'b0);

    // Random full-word bursts.
    for (int t = 0; t < 3; t++) begin
      logic [AW-1:0] ra;
      logic [7:0]    rl;
      logic [DW-1:0] rb;
      ra = AW'($urandom_range(0, 63) * 4);
      rl = 8'($urandom_range(0, 5));
      rb = $urandom;
      write_burst(ra, rl, 2'b01, 8'($urandom_range(0, 255)), rb, DW'($urandom_range(1, 999)), 4'hF);
      read_burst(ra, rl, 2'b01, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a write burst.
    aw_send(8'h60, 8'd3, 2'b01, 8'd7);
    w_send(32'h0005_0006, 4'hF);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_awready", 64'(s_axi_awready), 64'd0);
    check("mid_rst_wready", 64'(s_axi_wready), 64'd0);
    check("mid_rst_bvalid", 64'(s_axi_bvalid), 64'd0);
    check("mid_rst_bid", 64'(s_axi_bid), 64'd0);
    check("mid_rst_bresp", 64'(s_axi_bresp), 64'd0);
    check("mid_rst_arready", 64'(s_axi_arready), 64'd0);
    check("mid_rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    check("mid_rst_rlast", 64'(s_axi_rlast), 64'd0);
    check("mid_rst_rid", 64'(s_axi_rid), 64'd0);
    check("mid_rst_rresp", 64'(s_axi_rresp), 64'd0);
    check("mid_rst_rdata", 64'(s_axi_rdata), 64'd0);
    check("mid_rst_q", 64'(q), 64'd0);
    check("mid_rst_mac", 64'(mac_out), 64'd0);
    m_q = '0; m_mac = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_awready", 64'(s_axi_awready), 64'd1);
    check("post_rst_no_b", 64'(s_axi_bvalid), 64'd0);
    write_burst(8'h60, 8'd3, 2'b01, 8'd8, 32'h0002_0003, 32'h0001_0000, 4'hF);
    read_burst(8'h60, 8'd3, 2'b01, 8'd8, 1'b0);

    // ---------------------------------------------------------- final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case a wait loop is bypassed.
  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
